// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   MEM pipeline stage of the RISC-V core, between execute and writeback.
//   Takes one execute record per valid/ready handshake. Non-memory records go
//   straight to the writeback register. LD/SD records run a double-word access
//   on the data bus through a three-state FSM (IDLE, ADDR, DATA). Upstream is
//   stalled while an access is in flight or while the writeback register holds
//   a record that has not been consumed.
//
//   Optional feature macro: MEM_MISALIGN_CHECK_EN
//     defined   : a memory record whose address has bits [2:0] != 0 issues no
//                 bus request; it completes in one cycle with out_regwrite=0
//                 and out_misalign=1.
//     undefined : the access is aligned down (dreq_addr[2:0]=0) and
//                 out_misalign is tied to 0.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   in_valid/in_ready               execute-side handshake
//   in_result                       ALU result (address or writeback value)
//   in_wdata                        store data
//   in_memread/in_memwrite          LD / SD flags (both set = store)
//   in_dst/in_regwrite              destination register and write enable
//   dreq_valid/addr/size/strobe/data  data-bus request
//   dresp_addr_ok/data_ok/data      data-bus response
//   out_valid/out_ready             writeback-side handshake
//   out_dst/out_regwrite/out_wdata  writeback record
//   out_misalign                    misaligned-access flag
// -----------------------------------------------------------------------------
module memory_stage #(
    parameter int XLEN      = 64,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_result,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic                 in_memread,
    input  logic                 in_memwrite,
    input  logic [REGADDR_W-1:0] in_dst,
    input  logic                 in_regwrite,
    output logic                 dreq_valid,
    output logic [XLEN-1:0]      dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [7:0]           dreq_strobe,
    output logic [XLEN-1:0]      dreq_data,
    input  logic                 dresp_addr_ok,
    input  logic                 dresp_data_ok,
    input  logic [XLEN-1:0]      dresp_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REGADDR_W-1:0] out_dst,
    output logic                 out_regwrite,
    output logic [XLEN-1:0]      out_wdata,
    output logic                 out_misalign
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Double-word aligned form of an address (low three bits cleared).
    function automatic logic [XLEN-1:0] align_dword(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] res;
        res        = addr;
        res[2:0]   = 3'b000;
        return res;
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [XLEN-1:0]      req_addr_r;
    logic [XLEN-1:0]      req_data_r;
    logic                 req_store_r;
    logic [REGADDR_W-1:0] req_dst_r;
    logic                 req_regwrite_r;

    logic                 out_valid_r;
    logic [REGADDR_W-1:0] out_dst_r;
    logic                 out_regwrite_r;
    logic [XLEN-1:0]      out_wdata_r;
    logic                 out_misalign_r;

    logic                 transfer_s;
    logic                 in_is_mem_s;
    logic                 misalign_s;
    logic                 mem_start_s;
    logic                 complete_s;

    assign in_ready    = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    assign transfer_s  = in_valid && in_ready;
    assign in_is_mem_s = in_memread || in_memwrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_s  = in_is_mem_s && (in_result[2:0] != 3'b000);
`else
    assign misalign_s  = 1'b0;
`endif

    // A misaligned record (check enabled) never reaches the bus.
    assign mem_start_s = transfer_s && in_is_mem_s && !misalign_s;

    // Next-state and completion decode for the bus-access FSM.
    always_comb begin
        state_nxt_s = state_r;
        complete_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A data_ok seen here belongs to no access and is ignored.
                if (mem_start_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (dresp_addr_ok && dresp_data_ok) begin
                    complete_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (dresp_addr_ok) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (dresp_data_ok) begin
                    complete_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                complete_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch: holds the memory record so dreq_* stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_r     <= {XLEN{1'b0}};
            req_data_r     <= {XLEN{1'b0}};
            req_store_r    <= 1'b0;
            req_dst_r      <= {REGADDR_W{1'b0}};
            req_regwrite_r <= 1'b0;
        end else if (mem_start_s) begin
`ifdef MEM_MISALIGN_CHECK_EN
            req_addr_r     <= in_result;
`else
            req_addr_r     <= align_dword(in_result);
`endif
            req_data_r     <= in_wdata;
            // memread together with memwrite is treated as a store.
            req_store_r    <= in_memwrite;
            req_dst_r      <= in_dst;
            req_regwrite_r <= in_regwrite;
        end else begin
            req_addr_r     <= req_addr_r;
            req_data_r     <= req_data_r;
            req_store_r    <= req_store_r;
            req_dst_r      <= req_dst_r;
            req_regwrite_r <= req_regwrite_r;
        end
    end

    // Writeback register: loaded on completion or on a record that bypasses the bus,
    // held under back-pressure, emptied once consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r    <= 1'b0;
            out_dst_r      <= {REGADDR_W{1'b0}};
            out_regwrite_r <= 1'b0;
            out_wdata_r    <= {XLEN{1'b0}};
            out_misalign_r <= 1'b0;
        end else if (complete_s) begin
            out_valid_r    <= 1'b1;
            out_dst_r      <= req_dst_r;
            out_regwrite_r <= req_store_r ? 1'b0 : req_regwrite_r;
            out_wdata_r    <= req_store_r ? {XLEN{1'b0}} : dresp_data;
            out_misalign_r <= 1'b0;
        end else if (transfer_s && !in_is_mem_s) begin
            out_valid_r    <= 1'b1;
            out_dst_r      <= in_dst;
            out_regwrite_r <= in_regwrite;
            out_wdata_r    <= in_result;
            out_misalign_r <= 1'b0;
        end else if (transfer_s && misalign_s) begin
            out_valid_r    <= 1'b1;
            out_dst_r      <= in_dst;
            out_regwrite_r <= 1'b0;
            out_wdata_r    <= {XLEN{1'b0}};
            out_misalign_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r    <= 1'b0;
            out_dst_r      <= out_dst_r;
            out_regwrite_r <= out_regwrite_r;
            out_wdata_r    <= out_wdata_r;
            out_misalign_r <= 1'b0;
        end else begin
            out_valid_r    <= out_valid_r;
            out_dst_r      <= out_dst_r;
            out_regwrite_r <= out_regwrite_r;
            out_wdata_r    <= out_wdata_r;
            out_misalign_r <= out_misalign_r;
        end
    end

    // The bus request is live exactly while the FSM is outside IDLE.
    assign dreq_valid   = (state_r != ST_IDLE);
    assign dreq_addr    = req_addr_r;
    assign dreq_size    = 3'b011;
    assign dreq_strobe  = req_store_r ? 8'hFF : 8'h00;
    assign dreq_data    = req_data_r;

    assign out_valid    = out_valid_r;
    assign out_dst      = out_dst_r;
    assign out_regwrite = out_regwrite_r;
    assign out_wdata    = out_wdata_r;
`ifdef MEM_MISALIGN_CHECK_EN
    assign out_misalign = out_misalign_r;
`else
    assign out_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//   Self-checking bench for memory_stage: directed scenarios followed by a
//   randomized run scored against a record-level reference model (in-order
//   queue of expected writeback records plus a reference memory image).
// -----------------------------------------------------------------------------
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic [63:0] in_wdata;
    logic        in_memread;
    logic        in_memwrite;
    logic [4:0]  in_dst;
    logic        in_regwrite;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_dst;
    logic        out_regwrite;
    logic [63:0] out_wdata;
    logic        out_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_wdata(in_wdata), .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_dst(in_dst), .in_regwrite(in_regwrite),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst),
        .out_regwrite(out_regwrite), .out_wdata(out_wdata), .out_misalign(out_misalign)
    );

    typedef struct packed {
        logic [4:0]  dst;
        logic        regwrite;
        logic [63:0] wdata;
        logic        misalign;
        logic        chk_wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] bus_mem [logic [63:0]];

    // Contents of never-written memory locations.
    function automatic logic [63:0] mem_init(input logic [63:0] a);
        return a ^ 64'h5A5A_0F0F_A5A5_F0F0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_result = 64'd0; in_wdata = 64'd0;
        in_memread = 1'b0; in_memwrite = 1'b0; in_dst = 5'd0; in_regwrite = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rst_dreq_valid got %b exp 0", dreq_valid); end
        checks++; if (out_regwrite !== 1'b0) begin errors++; $display("FAIL rst_out_regwrite got %b exp 0", out_regwrite); end
        checks++; if (out_dst !== 5'd0) begin errors++; $display("FAIL rst_out_dst got %0d exp 0", out_dst); end
        checks++; if (out_wdata !== 64'd0) begin errors++; $display("FAIL rst_out_wdata got %h exp 0", out_wdata); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL rst_out_misalign got %b exp 0", out_misalign); end
        reset = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_alu();
        in_valid = 1'b1; in_result = 64'h1234; in_dst = 5'd5; in_regwrite = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_out_valid got %b exp 1", out_valid); end
        checks++; if (out_dst !== 5'd5) begin errors++; $display("FAIL alu_out_dst got %0d exp 5", out_dst); end
        checks++; if (out_wdata !== 64'h1234) begin errors++; $display("FAIL alu_out_wdata got %h exp 1234", out_wdata); end
        checks++; if (out_regwrite !== 1'b1) begin errors++; $display("FAIL alu_out_regwrite got %b exp 1", out_regwrite); end
        step();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL alu_consumed got %b exp 0", out_valid); end
        step();
    endtask

    task automatic test_load();
        in_valid = 1'b1; in_memread = 1'b1; in_result = 64'h8000_1000; in_dst = 5'd7; in_regwrite = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_in_ready got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0; in_memread = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            dresp_addr_ok = (c == 2);
            dresp_data_ok = (c == 4);
            dresp_data    = (c == 4) ? 64'hDEAD_BEEF : 64'h0BAD_0BAD_0BAD_0BAD;
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_stall_%0d got %b exp 0", c, in_ready); end
            checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL ld_dreq_valid_%0d got %b exp 1", c, dreq_valid); end
            checks++; if (dreq_addr !== 64'h8000_1000) begin errors++; $display("FAIL ld_dreq_addr_%0d got %h exp 80001000", c, dreq_addr); end
            checks++; if (dreq_strobe !== 8'h00) begin errors++; $display("FAIL ld_strobe_%0d got %h exp 00", c, dreq_strobe); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ld_early_out_%0d got %b exp 0", c, out_valid); end
            step();
        end
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ld_out_valid got %b exp 1", out_valid); end
        checks++; if (out_wdata !== 64'hDEAD_BEEF) begin errors++; $display("FAIL ld_out_wdata got %h exp deadbeef", out_wdata); end
        checks++; if (out_regwrite !== 1'b1) begin errors++; $display("FAIL ld_out_regwrite got %b exp 1", out_regwrite); end
        checks++; if (out_dst !== 5'd7) begin errors++; $display("FAIL ld_out_dst got %0d exp 7", out_dst); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL ld_dreq_drop got %b exp 0", dreq_valid); end
        step();
    endtask

    task automatic test_store();
        in_valid = 1'b1; in_memwrite = 1'b1; in_result = 64'h8000_0008; in_wdata = 64'h55;
        in_dst = 5'd3; in_regwrite = 1'b1;
        step();
        in_valid = 1'b0; in_memwrite = 1'b0;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
        @(negedge clk);
        checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL sd_dreq_valid got %b exp 1", dreq_valid); end
        checks++; if (dreq_strobe !== 8'hFF) begin errors++; $display("FAIL sd_strobe got %h exp ff", dreq_strobe); end
        checks++; if (dreq_size !== 3'b011) begin errors++; $display("FAIL sd_size got %b exp 011", dreq_size); end
        checks++; if (dreq_data !== 64'h55) begin errors++; $display("FAIL sd_data got %h exp 55", dreq_data); end
        checks++; if (dreq_addr !== 64'h8000_0008) begin errors++; $display("FAIL sd_addr got %h exp 80000008", dreq_addr); end
        step();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sd_out_valid got %b exp 1", out_valid); end
        checks++; if (out_regwrite !== 1'b0) begin errors++; $display("FAIL sd_out_regwrite got %b exp 0", out_regwrite); end
        checks++; if (out_wdata !== 64'd0) begin errors++; $display("FAIL sd_out_wdata got %h exp 0", out_wdata); end
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL sd_dreq_drop got %b exp 0", dreq_valid); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 64'hAAAA; in_dst = 5'd10; in_regwrite = 1'b1;
        step();
        in_result = 64'hBBBB; in_dst = 5'd11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d got %b exp 1", k, out_valid); end
            checks++; if (out_dst !== 5'd10) begin errors++; $display("FAIL bp_out_dst_%0d got %0d exp 10", k, out_dst); end
            checks++; if (out_wdata !== 64'hAAAA) begin errors++; $display("FAIL bp_out_wdata_%0d got %h exp aaaa", k, out_wdata); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d got %b exp 0", k, in_ready); end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid got %b exp 1", out_valid); end
        checks++; if (out_dst !== 5'd11) begin errors++; $display("FAIL b2b_out_dst got %0d exp 11", out_dst); end
        checks++; if (out_wdata !== 64'hBBBB) begin errors++; $display("FAIL b2b_out_wdata got %h exp bbbb", out_wdata); end
        step();
    endtask

    task automatic test_reset_mid_access();
        in_valid = 1'b1; in_memread = 1'b1; in_result = 64'h8000_2000; in_dst = 5'd4; in_regwrite = 1'b1;
        step();
        in_valid = 1'b0; in_memread = 1'b0;
        dresp_addr_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL rmid_in_data got %b exp 1", dreq_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL rmid_dreq_valid got %b exp 0", dreq_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
        dresp_data_ok = 1'b1; dresp_data = 64'h1234_5678;
        step();
        dresp_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stray_data_ok got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
        step();
    endtask

    task automatic test_misalign();
        in_valid = 1'b1; in_memread = 1'b1; in_result = 64'h8000_0004; in_dst = 5'd6; in_regwrite = 1'b1;
        step();
        in_valid = 1'b0; in_memread = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        checks++; if (dreq_valid !== 1'b0) begin errors++; $display("FAIL mis_dreq_valid got %b exp 0", dreq_valid); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_out_valid got %b exp 1", out_valid); end
        checks++; if (out_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %b exp 1", out_misalign); end
        checks++; if (out_regwrite !== 1'b0) begin errors++; $display("FAIL mis_regwrite got %b exp 0", out_regwrite); end
        step();
`else
        @(negedge clk);
        checks++; if (dreq_valid !== 1'b1) begin errors++; $display("FAIL mis_dreq_valid got %b exp 1", dreq_valid); end
        checks++; if (dreq_addr !== 64'h8000_0000) begin errors++; $display("FAIL mis_align_down got %h exp 80000000", dreq_addr); end
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 64'hCAFE;
        step();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        @(negedge clk);
        checks++; if (out_wdata !== 64'hCAFE) begin errors++; $display("FAIL mis_wdata got %h exp cafe", out_wdata); end
        checks++; if (out_misalign !== 1'b0) begin errors++; $display("FAIL mis_flag got %b exp 0", out_misalign); end
        step();
`endif
    endtask

    task automatic test_random();
        localparam int NREC = 300;
        int   sent = 0;
        int   got = 0;
        logic have_rec = 1'b0;
        logic addr_acc = 1'b0;
        exp_t e;
        logic [63:0] a;
        for (int cyc = 0; cyc < 20000 && got < NREC; cyc++) begin
            if (!have_rec && sent < NREC && ($urandom % 4) != 0) begin
                int kind;
                kind        = $urandom % 3;
                in_dst      = 5'($urandom % 32);
                in_regwrite = 1'($urandom % 2);
                in_wdata    = {$urandom, $urandom};
                in_memwrite = (kind == 2);
                in_memread  = (kind == 1) || (kind == 2 && ($urandom % 4) == 0);
                if (kind == 0) in_result = {$urandom, $urandom};
                else in_result = 64'h8000_0000 + 64'(($urandom % 16) * 8)
                               + ((($urandom % 4) == 0) ? 64'($urandom % 8) : 64'd0);
                have_rec = 1'b1;
            end
            in_valid  = have_rec;
            out_ready = (($urandom % 4) != 0);
            if (dreq_valid && !addr_acc) begin
                dresp_addr_ok = 1'($urandom % 2);
                dresp_data_ok = dresp_addr_ok && (($urandom % 2) == 0);
            end else if (dreq_valid) begin
                dresp_addr_ok = 1'b0;
                dresp_data_ok = (($urandom % 3) == 0);
            end else begin
                dresp_addr_ok = 1'b0;
                dresp_data_ok = (($urandom % 8) == 0);
            end
            if (dreq_valid && dreq_strobe == 8'h00)
                dresp_data = bus_mem.exists(dreq_addr) ? bus_mem[dreq_addr] : mem_init(dreq_addr);
            else
                dresp_data = {$urandom, $urandom};
            @(negedge clk);
            if (dreq_valid) begin
                checks++; if (dreq_size !== 3'b011) begin errors++; $display("FAIL rnd_size got %b exp 011", dreq_size); end
            end
            if (in_valid && in_ready) begin
                e.dst = in_dst; e.misalign = 1'b0; e.chk_wdata = 1'b1;
                a = in_result; a[2:0] = 3'b000;
                if (!in_memread && !in_memwrite) begin
                    e.regwrite = in_regwrite; e.wdata = in_result;
`ifdef MEM_MISALIGN_CHECK_EN
                end else if (in_result[2:0] != 3'b000) begin
                    e.regwrite = 1'b0; e.wdata = 64'd0; e.misalign = 1'b1; e.chk_wdata = 1'b0;
`endif
                end else if (in_memwrite) begin
                    e.regwrite = 1'b0; e.wdata = 64'd0;
                    ref_mem[a] = in_wdata;
                end else begin
                    e.regwrite = in_regwrite;
                    e.wdata = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
                end
                exp_q.push_back(e);
                have_rec = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("FAIL rnd_unexpected_out got dst %0d exp none", out_dst);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (out_dst !== e.dst) begin errors++; $display("FAIL rnd_dst got %0d exp %0d", out_dst, e.dst); end
                    checks++; if (out_regwrite !== e.regwrite) begin errors++; $display("FAIL rnd_regwrite got %b exp %b", out_regwrite, e.regwrite); end
                    checks++; if (out_misalign !== e.misalign) begin errors++; $display("FAIL rnd_misalign got %b exp %b", out_misalign, e.misalign); end
                    if (e.chk_wdata) begin
                        checks++; if (out_wdata !== e.wdata) begin errors++; $display("FAIL rnd_wdata got %h exp %h", out_wdata, e.wdata); end
                    end
                end
            end
            if (dreq_valid && dresp_data_ok && (addr_acc || dresp_addr_ok)) begin
                if (dreq_strobe == 8'hFF) bus_mem[dreq_addr] = dreq_data;
                addr_acc = 1'b0;
            end else if (dreq_valid && dresp_addr_ok) begin
                addr_acc = 1'b1;
            end
            step();
        end
        checks++; if (got != NREC) begin errors++; $display("FAIL rnd_timeout got %0d records exp %0d", got, NREC); end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_backpressure();
        test_reset_mid_access();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
